// File: rtl/system_entrada_ctrl_if.sv
// Avalon-MM slave bus for the input-sampling controller: word address,
// read/write strobes, write data, registered read data and the level irq.
interface system_entrada_ctrl_if;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport slave  (input address, read, write, writedata, output readdata, irq);
   modport master (output address, read, write, writedata, input readdata, irq);
endinterface

// File: rtl/system_entrada_ctrl.sv
// system_entrada_ctrl: synchronises and debounces the switch/key port,
// commits each new stable value into a snapshot FIFO, and exposes it over
// Avalon-MM with a maskable level interrupt.
// Optional build macro ENTRADA_TIMESTAMP_EN adds a 32-bit cycle counter whose
// value is stored with every pushed entry and read back at address 4.
module system_entrada_ctrl #(
   parameter int WIDTH           = 19,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in_port,
   system_entrada_ctrl_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, COUNT} state_t;

   logic [WIDTH-1:0] s1, s2;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cand_q, cand_d, stable_q, stable_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count_q;
   logic             overflow_q, mask_q;
   logic             empty, full, pop, do_push, ovf_evt, ovf_clr;
   logic [31:0]      rd_mux;

   // Only bits 6 (STATUS) and 0 (IRQMASK) of writedata are meaningful
   logic unused_wdata;
   assign unused_wdata = ^{bus.writedata[31:7], bus.writedata[5:1]};

   // Two-flop synchroniser for the asynchronous board inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
      end
   end

   // Debounce FSM state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   // Debounce next state: any mismatch against the candidate restarts the
   // count, so a value commits only after holding for the full window
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (s2 != stable_q) begin
               cand_d  = s2;
               cnt_d   = '0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (s2 != cand_q) begin
               cand_d = s2;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_d = cand_q;
               push     = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign pop     = bus.read && (bus.address == 3'd0) && !empty;
   // A pop on the same edge frees the slot, so a push into a full FIFO is kept
   assign do_push = push && (!full || pop);
   assign ovf_evt = push && full && !pop;
   assign ovf_clr = bus.write && (bus.address == 3'd1) && bus.writedata[6];

   // Snapshot storage; contents are only meaningful behind the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= cand_q;
   end

   // FIFO pointers, occupancy and sticky overflow (new event beats clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         count_q    <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, pop};
         overflow_q <= ovf_evt || (overflow_q && !ovf_clr);
      end
   end

`ifdef ENTRADA_TIMESTAMP_EN
   logic [31:0] tcnt_q;
   logic [31:0] ts_mem [FIFO_DEPTH];

   // Free-running cycle counter, wraps naturally at 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tcnt_q <= '0;
      else       tcnt_q <= tcnt_q + 32'd1;
   end

   // Timestamp captured on the commit edge alongside the entry
   always_ff @(posedge clk) begin
      if (do_push) ts_mem[wr_ptr] <= tcnt_q;
   end
`endif

   // Register-map read mux; unmapped addresses fall through to zero
   always_comb begin
      rd_mux = 32'h0;
      case (bus.address)
         3'd0: begin
            if (!empty) begin
               rd_mux[31]        = 1'b1;
               rd_mux[WIDTH-1:0] = mem[rd_ptr];
            end
         end
         3'd1: begin
            rd_mux[3:0] = 4'(count_q);
            rd_mux[4]   = empty;
            rd_mux[5]   = full;
            rd_mux[6]   = overflow_q;
         end
         3'd2: rd_mux[0] = mask_q;
         3'd3: rd_mux[WIDTH-1:0] = stable_q;
`ifdef ENTRADA_TIMESTAMP_EN
         3'd4: if (!empty) rd_mux = ts_mem[rd_ptr];
`endif
         default: rd_mux = 32'h0;
      endcase
   end

   // Registered read data, interrupt mask and level interrupt (one-cycle lag)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.readdata <= 32'h0;
         mask_q       <= 1'b0;
         bus.irq      <= 1'b0;
      end else begin
         if (bus.read) bus.readdata <= rd_mux;
         if (bus.write && bus.address == 3'd2) mask_q <= bus.writedata[0];
         bus.irq <= mask_q && !empty;
      end
   end
endmodule

// File: tb/tb_system_entrada_ctrl.sv
// Directed bench for system_entrada_ctrl (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Reads push their expected readdata into a queue; a monitor pops and
// compares on the falling edge after each read strobe.
module tb_system_entrada_ctrl;
   localparam int WIDTH = 19;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] in_port = '0;

   system_entrada_ctrl_if bus();

   system_entrada_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_port(in_port), .bus(bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];
   string       name_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every edge with read=1 yields one registered readdata value
   initial begin
      forever begin
         @(posedge clk);
         if (bus.read === 1'b1) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read: got %h expected none", bus.readdata);
            end else begin
               chk(name_q.pop_front(), bus.readdata, exp_q.pop_front());
            end
         end
      end
   end

   // All driver tasks start and end at a falling edge
   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
      bus.address = a;
      bus.read    = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      bus.read = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address   = a;
      bus.writedata = d;
      bus.write     = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.address   = 3'd0;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.writedata = 32'h0;
      step(3);
      chk("rst_readdata", bus.readdata, 32'h0);
      chk("rst_irq", {31'b0, bus.irq}, 32'h0);
      reset = 1'b0;
      rd(3'd1, 32'h10, "rst_status");
      rd(3'd3, 32'h0,  "rst_live");
      rd(3'd2, 32'h0,  "rst_mask");
      rd(3'd0, 32'h0,  "rst_data_empty");

      // Clean change: count becomes 1 on edge 7, so the edge-8 read sees it
      in_port = 19'h5;
      for (int i = 0; i < 8; i++) rd(3'd1, (i == 7) ? 32'h01 : 32'h10, "clean_status");
      chk("clean_irq_masked", {31'b0, bus.irq}, 32'h0);
      rd(3'd3, 32'h5, "clean_live");
      rd(3'd0, 32'h80000005, "clean_data");

      // Bounce: 2-clock toggles never survive the window
      for (int i = 0; i < 10; i++) begin
         in_port = i[0] ? 19'h0 : 19'h1;
         step(2);
      end
      in_port = 19'h1;
      for (int i = 0; i < 8; i++) rd(3'd1, (i == 7) ? 32'h01 : 32'h10, "bounce_status");
      rd(3'd1, 32'h01, "bounce_single");

      // Interrupt enable and pop of the only entry
      wr(3'd2, 32'h1);
      chk("irq_lag", {31'b0, bus.irq}, 32'h0);
      step(1);
      chk("irq_set", {31'b0, bus.irq}, 32'h1);
      rd(3'd2, 32'h1, "mask_rb");
      rd(3'd0, 32'h80000001, "pop_data");
      chk("irq_hold", {31'b0, bus.irq}, 32'h1);
      step(1);
      chk("irq_clear", {31'b0, bus.irq}, 32'h0);
      rd(3'd1, 32'h10, "pop_status");
      rd(3'd0, 32'h0, "pop_empty_data");

      // Overflow: fifth commit is dropped
      for (int i = 1; i <= 5; i++) begin
         in_port = 19'(i * 16);
         step(10);
      end
      rd(3'd1, 32'h64, "ovf_status");
      chk("ovf_irq", {31'b0, bus.irq}, 32'h1);
      wr(3'd3, 32'h0);
      rd(3'd3, 32'h50, "ovf_live");
      wr(3'd1, 32'h40);
      rd(3'd1, 32'h24, "ovf_clear");

      // Full FIFO: pop lands on the commit edge (edge 7)
      in_port = 19'h60;
      step(6);
      rd(3'd0, 32'h80000010, "fullpp_pop");
      rd(3'd1, 32'h24, "fullpp_status");
      rd(3'd0, 32'h80000020, "drain0");
      rd(3'd0, 32'h80000030, "drain1");
      rd(3'd0, 32'h80000040, "drain2");
      rd(3'd0, 32'h80000060, "drain3");
      rd(3'd1, 32'h10, "drain_status");

      // Reset two clocks into COUNT
      in_port = 19'h3;
      step(5);
      reset = 1'b1;
      #1;
      chk("midrst_readdata", bus.readdata, 32'h0);
      chk("midrst_irq", {31'b0, bus.irq}, 32'h0);
      step(2);
      reset = 1'b0;
      rd(3'd1, 32'h10, "midrst_status");
      step(12);
      rd(3'd1, 32'h01, "recommit_status");
      rd(3'd2, 32'h0, "recommit_mask");
      rd(3'd0, 32'h80000003, "recommit_data");
      rd(3'd1, 32'h10, "recommit_empty");
      rd(3'd5, 32'h0, "unmapped");
`ifndef ENTRADA_TIMESTAMP_EN
      rd(3'd4, 32'h0, "tstamp_off");
`endif
      step(2);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL pending_reads: got %0d expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
